// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one backing-memory port between the
// instruction-side and data-side cache controllers, with a transaction watchdog.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie-breaking;
// otherwise the data side always wins a tie.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic [31:0] i_write_data,
  input  logic        i_read_req,
  input  logic        i_write_req,
  output logic [31:0] i_read_data,
  output logic        i_ready,
  input  logic [31:0] d_address,
  input  logic [31:0] d_write_data,
  input  logic        d_read_req,
  input  logic        d_write_req,
  output logic [31:0] d_read_data,
  output logic        d_ready,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read_req,
  output logic        mem_write_req,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ready,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {StIdle, StGrant, StResp} state_e;

  localparam logic [TO_W-1:0] ToLimit = TO_W'(TIMEOUT_CYCLES);
  localparam bit              WdEn    = (TIMEOUT_CYCLES != 0);

  state_e            state_q, state_d;
  logic [1:0]        owner_q, owner_d;       // one-hot: bit0 = I, bit1 = D
  logic              is_write_q, is_write_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;
  logic              last_d_q, last_d_d;     // 1 when the data side was served last

  logic            pend_i, pend_d, win_d;
  logic [TO_W-1:0] wd_inc;

  assign pend_i = i_read_req | i_write_req;
  assign pend_d = d_read_req | d_write_req;
  assign wd_inc = wd_q + 1'b1;

`ifdef MEM_ARB_RR_EN
  // Round-robin: on a tie, serve the side that was not served last.
  always_comb begin
    win_d = pend_d;
    if (pend_i && pend_d) win_d = ~last_d_q;
  end
`else
  // Fixed priority: data side beats instruction side.
  always_comb begin
    win_d = pend_d;
  end
  logic unused_last_d;
  assign unused_last_d = last_d_q;
`endif

  // Next-state logic for the arbitration FSM and its datapath registers.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    wd_d       = wd_q;
    err_d      = err_q;
    last_d_d   = last_d_q;
    unique case (state_q)
      StIdle: begin
        wd_d  = '0;
        err_d = 1'b0;
        if (pend_i || pend_d) begin
          owner_d    = win_d ? 2'b10 : 2'b01;
          // Write wins over read when a side raises both.
          is_write_d = win_d ? d_write_req : i_write_req;
          addr_d     = win_d ? d_address : i_address;
          wdata_d    = win_d ? d_write_data : i_write_data;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        // Completion takes precedence over a coincident watchdog expiry.
        if (mem_ready) begin
          if (owner_q[1]) d_rdata_d = mem_read_data;
          else            i_rdata_d = mem_read_data;
          state_d = StResp;
        end else begin
          wd_d = wd_inc;
          if (WdEn && (wd_inc == ToLimit)) begin
            if (owner_q[1]) d_rdata_d = '0;
            else            i_rdata_d = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StResp: begin
        last_d_d = owner_q[1];
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      owner_q    <= 2'b00;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      wd_q       <= '0;
      err_q      <= 1'b0;
      last_d_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
      last_d_q   <= last_d_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    grant          = (state_q == StGrant) ? owner_q : 2'b00;
    mem_read_req   = (state_q == StGrant) && !is_write_q;
    mem_write_req  = (state_q == StGrant) && is_write_q;
    mem_address    = addr_q;
    mem_write_data = wdata_q;
    i_ready        = (state_q == StResp) && owner_q[0];
    d_ready        = (state_q == StResp) && owner_q[1];
    timeout_err    = (state_q == StResp) && err_q;
    i_read_data    = i_rdata_q;
    d_read_data    = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (watchdog set to 4 cycles).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_address, i_write_data, d_address, d_write_data;
  logic        i_read_req, i_write_req, d_read_req, d_write_req;
  logic [31:0] i_read_data, d_read_data;
  logic        i_ready, d_ready;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_read_req, mem_write_req, mem_ready;
  logic [1:0]  grant;
  logic        timeout_err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_write_data(i_write_data),
    .i_read_req(i_read_req), .i_write_req(i_write_req),
    .i_read_data(i_read_data), .i_ready(i_ready),
    .d_address(d_address), .d_write_data(d_write_data),
    .d_read_req(d_read_req), .d_write_req(d_write_req),
    .d_read_data(d_read_data), .d_ready(d_ready),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready),
    .grant(grant), .timeout_err(timeout_err)
  );

`ifdef MEM_ARB_RR_EN
  localparam logic [1:0] FirstTie = 2'b01;
`else
  localparam logic [1:0] FirstTie = 2'b10;
`endif

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    settle();
    total++; if (grant !== 2'b00) $display("FAIL reset_grant got=%b exp=00", grant); else passed++;
    total++; if ({mem_read_req, mem_write_req, i_ready, d_ready, timeout_err} !== 5'b0)
      $display("FAIL reset_ctl got=%b exp=00000",
               {mem_read_req, mem_write_req, i_ready, d_ready, timeout_err}); else passed++;
    total++; if ({i_read_data, d_read_data, mem_address, mem_write_data} !== 128'h0)
      $display("FAIL reset_data got=%h exp=0",
               {i_read_data, d_read_data, mem_address, mem_write_data}); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_collision();
    logic [1:0] second;
    logic [31:0] exp_addr;
    second = ~FirstTie;
    i_address = 32'h300; i_read_req = 1'b1;
    d_address = 32'h200; d_write_data = 32'h1234_5678; d_write_req = 1'b1;
    tick();  // first GRANT
    settle();
    exp_addr = FirstTie[1] ? 32'h200 : 32'h300;
    total++; if (grant !== FirstTie) $display("FAIL coll_first_grant got=%b exp=%b", grant, FirstTie); else passed++;
    total++; if (mem_address !== exp_addr) $display("FAIL coll_first_addr got=%h exp=%h", mem_address, exp_addr); else passed++;
    total++; if (mem_write_req !== FirstTie[1]) $display("FAIL coll_first_wr got=%b exp=%b", mem_write_req, FirstTie[1]); else passed++;
    mem_ready = 1'b1; mem_read_data = 32'h1111_1111;
    tick();  // RESP
    mem_ready = 1'b0; mem_read_data = 32'h0;
    settle();
    total++; if ({d_ready, i_ready} !== FirstTie) $display("FAIL coll_first_ready got=%b exp=%b", {d_ready, i_ready}, FirstTie); else passed++;
    if (FirstTie[1]) d_write_req = 1'b0; else i_read_req = 1'b0;
    tick();  // IDLE
    settle();
    total++; if (grant !== 2'b00) $display("FAIL coll_idle_grant got=%b exp=00", grant); else passed++;
    tick();  // second GRANT, three cycles after first mem_ready
    settle();
    total++; if (grant !== second) $display("FAIL coll_second_grant got=%b exp=%b", grant, second); else passed++;
    mem_ready = 1'b1; mem_read_data = 32'h2222_2222;
    tick();
    mem_ready = 1'b0; mem_read_data = 32'h0;
    settle();
    total++; if ({d_ready, i_ready} !== second) $display("FAIL coll_second_ready got=%b exp=%b", {d_ready, i_ready}, second); else passed++;
    total++; if ({i_read_data, d_read_data} !== {32'h2222_2222, 32'h1111_1111}
                 && {i_read_data, d_read_data} !== {32'h1111_1111, 32'h2222_2222})
      $display("FAIL coll_rdata got=%h", {i_read_data, d_read_data}); else passed++;
    total++; if ((second[1] ? d_read_data : i_read_data) !== 32'h2222_2222)
      $display("FAIL coll_second_rdata got=%h exp=22222222", second[1] ? d_read_data : i_read_data); else passed++;
    i_read_req = 1'b0; d_write_req = 1'b0;
    tick();
  endtask

  // Both sides hold requests across three back-to-back transactions.
  task automatic test_back_to_back();
    logic [1:0] exp_own [3];
`ifdef MEM_ARB_RR_EN
    exp_own = '{2'b01, 2'b10, 2'b01};
`else
    exp_own = '{2'b10, 2'b10, 2'b10};
`endif
    i_read_req = 1'b1; i_address = 32'h40;
    d_read_req = 1'b1; d_address = 32'h80;
    for (int r = 0; r < 3; r++) begin
      tick();
      settle();
      total++; if (grant !== exp_own[r]) $display("FAIL b2b_grant[%0d] got=%b exp=%b", r, grant, exp_own[r]); else passed++;
      mem_ready = 1'b1; mem_read_data = 32'h100 + r;
      tick();
      mem_ready = 1'b0;
      settle();
      total++; if ({d_ready, i_ready} !== exp_own[r]) $display("FAIL b2b_ready[%0d] got=%b exp=%b", r, {d_ready, i_ready}, exp_own[r]); else passed++;
      tick();
    end
    i_read_req = 1'b0; d_read_req = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    int rd_cnt = 0;
    i_address = 32'h100; i_read_req = 1'b1;
    tick();  // GRANT 1
    settle();
    total++; if (grant !== 2'b01) $display("FAIL rd_grant got=%b exp=01", grant); else passed++;
    total++; if (mem_address !== 32'h100) $display("FAIL rd_addr got=%h exp=00000100", mem_address); else passed++;
    i_address = 32'hFFFF_FFFF;  // requester inputs may change freely in GRANT
    for (int k = 0; k < 3; k++) begin
      if (mem_read_req === 1'b1 && mem_write_req === 1'b0) rd_cnt++;
      if (k == 2) begin mem_ready = 1'b1; mem_read_data = 32'hDEAD_BEEF; end
      tick();
      settle();
    end
    mem_ready = 1'b0; mem_read_data = 32'h0;
    total++; if (rd_cnt !== 3) $display("FAIL rd_req_cycles got=%0d exp=3", rd_cnt); else passed++;
    total++; if (i_ready !== 1'b1 || mem_read_req !== 1'b0) $display("FAIL rd_ready got=%b req=%b exp=1,0", i_ready, mem_read_req); else passed++;
    total++; if (i_read_data !== 32'hDEAD_BEEF) $display("FAIL rd_data got=%h exp=deadbeef", i_read_data); else passed++;
    i_read_req = 1'b0;
    tick();  // IDLE
    mem_ready = 1'b1;  // stray mem_ready outside GRANT
    tick();
    mem_ready = 1'b0;
    settle();
    total++; if ({grant, i_ready, d_ready} !== 4'b0) $display("FAIL rd_idle got=%b exp=0000", {grant, i_ready, d_ready}); else passed++;
    total++; if (i_read_data !== 32'hDEAD_BEEF) $display("FAIL rd_hold got=%h exp=deadbeef", i_read_data); else passed++;
  endtask

  task automatic test_write_priority();
    d_address = 32'h400; d_write_data = 32'hCAFE_0000;
    d_read_req = 1'b1; d_write_req = 1'b1;
    tick();
    settle();
    total++; if ({mem_write_req, mem_read_req} !== 2'b10) $display("FAIL wp_req got=%b exp=10", {mem_write_req, mem_read_req}); else passed++;
    total++; if (mem_write_data !== 32'hCAFE_0000) $display("FAIL wp_wdata got=%h exp=cafe0000", mem_write_data); else passed++;
    mem_ready = 1'b1; mem_read_data = 32'h0BAD_F00D;
    tick();
    mem_ready = 1'b0;
    settle();
    total++; if (d_ready !== 1'b1 || d_read_data !== 32'h0BAD_F00D) $display("FAIL wp_resp got=%b/%h exp=1/0badf00d", d_ready, d_read_data); else passed++;
    d_read_req = 1'b0; d_write_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    d_address = 32'h500; d_read_req = 1'b1; mem_read_data = 32'h5555_5555;
    tick();  // GRANT 1
    for (int k = 0; k < 4; k++) begin
      settle();
      total++; if (grant !== 2'b10 || d_ready !== 1'b0) $display("FAIL to_grant[%0d] got=%b/%b exp=10/0", k, grant, d_ready); else passed++;
      tick();
    end
    settle();
    total++; if ({d_ready, timeout_err} !== 2'b11) $display("FAIL to_resp got=%b exp=11", {d_ready, timeout_err}); else passed++;
    total++; if (d_read_data !== 32'h0) $display("FAIL to_rdata got=%h exp=0", d_read_data); else passed++;
    d_read_req = 1'b0;
    tick();
    settle();
    total++; if ({grant, d_ready, timeout_err} !== 4'b0) $display("FAIL to_idle got=%b exp=0000", {grant, d_ready, timeout_err}); else passed++;
  endtask

  task automatic test_expiry_coincident();
    d_read_req = 1'b1; mem_read_data = 32'h0000_0077;
    tick();  // GRANT 1
    tick();
    tick();
    tick();  // GRANT 4: watchdog would expire here
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    settle();
    total++; if ({d_ready, timeout_err} !== 2'b10) $display("FAIL exp_resp got=%b exp=10", {d_ready, timeout_err}); else passed++;
    total++; if (d_read_data !== 32'h77) $display("FAIL exp_rdata got=%h exp=00000077", d_read_data); else passed++;
    d_read_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    i_address = 32'h600; i_read_req = 1'b1;
    tick();
    settle();
    total++; if (grant !== 2'b01) $display("FAIL rst_pre_grant got=%b exp=01", grant); else passed++;
    reset = 1'b1;
    mem_ready = 1'b1; mem_read_data = 32'h9999_9999;
    tick();
    mem_ready = 1'b0;
    settle();
    total++; if ({grant, mem_read_req, i_ready, d_ready, timeout_err} !== 6'b0)
      $display("FAIL rst_ctl got=%b exp=000000", {grant, mem_read_req, i_ready, d_ready, timeout_err}); else passed++;
    total++; if ({i_read_data, d_read_data, mem_address} !== 96'h0)
      $display("FAIL rst_data got=%h exp=0", {i_read_data, d_read_data, mem_address}); else passed++;
    reset = 1'b0;
    tick();
    settle();
    total++; if (grant !== 2'b01 || mem_address !== 32'h600) $display("FAIL rst_regrant got=%b/%h exp=01/00000600", grant, mem_address); else passed++;
    mem_ready = 1'b1; mem_read_data = 32'h0000_600D;
    tick();
    mem_ready = 1'b0;
    settle();
    total++; if (i_ready !== 1'b1 || i_read_data !== 32'h600D) $display("FAIL rst_resp got=%b/%h exp=1/0000600d", i_ready, i_read_data); else passed++;
    i_read_req = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    i_address = '0; i_write_data = '0; i_read_req = 1'b0; i_write_req = 1'b0;
    d_address = '0; d_write_data = '0; d_read_req = 1'b0; d_write_req = 1'b0;
    mem_read_data = '0; mem_ready = 1'b0;
    test_reset();
    test_collision();
    test_back_to_back();
    test_single_read();
    test_write_priority();
    test_timeout();
    test_expiry_coincident();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter sharing the single backing-memory interface between the instruction-side and data-side cache controllers. Each requester holds a level read or write request until it sees a one-cycle `ready` pulse. The arbiter grants one requester at a time, registers its address and data onto the memory port, and returns the response. A watchdog aborts memory transactions that never complete. It sits between the cache controllers and the main memory model or bus.

## Interface
**Parameters**
- `TIMEOUT_CYCLES`, 255: consecutive grant cycles without `mem_ready` before abort; 0 disables the watchdog.
- `TO_W`, 8: watchdog counter width; must satisfy `2**TO_W > TIMEOUT_CYCLES`.

**Ports**
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `i_address` in 32: instruction-side address.
- `i_write_data` in 32: instruction-side write data.
- `i_read_req` in 1: instruction-side read request.
- `i_write_req` in 1: instruction-side write request.
- `i_read_data` out 32, `i_ready` out 1: instruction-side response data and completion pulse.
- `d_address`, `d_write_data`, `d_read_req`, `d_write_req`, `d_read_data`, `d_ready`: same set for the data side.
- `mem_address` out 32, `mem_write_data` out 32, `mem_read_req` out 1, `mem_write_req` out 1: memory request.
- `mem_read_data` in 32, `mem_ready` in 1: memory response.
- `grant` out 2: one-hot owner of the memory port; bit0 = I, bit1 = D.
- `timeout_err` out 1: pulses with `ready` on an aborted transaction.

## Operation
- States: IDLE, GRANT, RESP. Registers: `owner`, `is_write`, latched address and write data, response data, watchdog count, `last_grant`.
- **IDLE**
  - A requester is pending if its read or write request is high.
  - If either is pending, choose a winner by the arbitration policy (see Configuration).
  - Latch the winner's address, write data, and `is_write` (write wins if both read and write are high). Go to GRANT.
- **GRANT**
  - `grant` = owner. `mem_read_req` = !`is_write`. `mem_write_req` = `is_write`. Memory address and data come from the latched copies; requester inputs may change freely.
  - On `mem_ready`: latch `mem_read_data` (latched for writes too) and go to RESP.
  - Otherwise, increment the watchdog. When the count reaches `TIMEOUT_CYCLES`, latch response data = 0, set the error flag, and go to RESP.
  - `mem_ready` in the same cycle as expiry counts as normal completion.
- **RESP**
  - The owner's `ready` = 1 and its `read_data` = latched data. `timeout_err` = flag.
  - Memory requests are low. Update `last_grant` = owner. Go to IDLE.
- The non-owner's `ready` is always 0. Its `read_data` holds its last value.
- Requests dropped mid-GRANT are ignored; the transaction completes and `ready` still pulses.
- `mem_ready` outside GRANT is ignored.
- `reset` mid-transaction returns to IDLE immediately; the in-flight transaction is lost and no `ready` is issued.

## Timing
- Reset values:
  - All outputs 0; `grant` = 00.
  - State IDLE, watchdog 0, `last_grant` = D.
- Request seen in IDLE at cycle N → `mem_*_req` and `grant` high at N+1.
- `mem_ready` at cycle M → requester `ready` at M+1 → IDLE at M+2.
- A requester that drops its request on `ready` is not re-granted.
- Minimum occupancy is 3 cycles per transaction (zero-wait memory). A queued competitor is granted at M+3.
- `mem_*_req` stays stable for the whole GRANT period.
- Timeout: `TIMEOUT_CYCLES` GRANT cycles without `mem_ready` → RESP on the next cycle.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin. On a tie, grant the requester opposite `last_grant`.
  - After reset I wins the first tie.
- Not defined:
  - Fixed priority: D always beats I.
  - `last_grant` is still tracked but unused.

## Test plan
- Single I read at address 0x100, memory returns 0xDEADBEEF after 2 wait cycles → `mem_read_req` high 3 cycles, `i_ready` one cycle with `i_read_data` = 0xDEADBEEF, `grant` = 01 during GRANT.
- Simultaneous I read and D write (0x200, 0x12345678), zero-wait memory:
  - Fixed priority: D served first, I granted 3 cycles later.
  - `MEM_ARB_RR_EN`: I first, then D; repeated collisions alternate.
- Both `d_read_req` and `d_write_req` high → write issued, `mem_write_req` = 1, `mem_read_req` = 0.
- `TIMEOUT_CYCLES` = 4, `mem_ready` never asserted → after 4 GRANT cycles, `d_ready` = 1, `timeout_err` = 1, `d_read_data` = 0, then IDLE.
- `mem_ready` coincident with expiry → normal completion, `timeout_err` = 0.
- `reset` asserted in GRANT → next cycle all outputs 0, no `ready` pulse; a new request afterwards is granted normally.
